// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage: default widths, ALU control codes,
// alu_op class encodings and R-type funct values.
package id_ex_operand_stage_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;
  localparam int unsigned ALUOP_W    = 4;
  localparam int unsigned FUNCT_W    = 6;

  localparam logic [ALUOP_W-1:0] ALU_AND     = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_OR      = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_ADD     = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_SUB     = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_SLT     = 4'b0111;
  localparam logic [ALUOP_W-1:0] ALU_NOR     = 4'b1100;
  localparam logic [ALUOP_W-1:0] ALU_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'b00,
    ALU_CLS_SUB   = 2'b01,
    ALU_CLS_RTYPE = 2'b10,
    ALU_CLS_BAD   = 2'b11
  } alu_class_e;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side, forwarding and EX-output signals of the ID/EX operand stage.
// master = surrounding pipeline, slave = the stage itself.
interface id_ex_operand_stage_if
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
);

  logic                 flush;
  logic                 id_valid;
  logic [REG_AW-1:0]    id_rs;
  logic [REG_AW-1:0]    id_rt;
  logic [REG_AW-1:0]    id_rd;
  logic [DATA_W-1:0]    id_rs_data;
  logic [DATA_W-1:0]    id_rt_data;
  logic [DATA_W-1:0]    id_imm;
  logic                 id_alu_src;
  alu_class_e           id_alu_op;
  logic [FUNCT_W-1:0]   id_funct;
  logic                 id_mem_read;
  logic                 id_reg_write;
  logic                 exmem_reg_write;
  logic [REG_AW-1:0]    exmem_rd;
  logic [DATA_W-1:0]    exmem_result;
  logic                 memwb_reg_write;
  logic [REG_AW-1:0]    memwb_rd;
  logic [DATA_W-1:0]    memwb_result;

  logic                 stall;
  logic                 ex_valid;
  logic [DATA_W-1:0]    opA;
  logic [DATA_W-1:0]    opB;
  logic [ALUOP_W-1:0]   ALUop;
  logic [REG_AW-1:0]    ex_rd;
  logic                 ex_reg_write;
  logic                 ex_mem_read;
  logic [DATA_W-1:0]    ex_store_data;
  logic                 illegal;

  modport master (
    output flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_alu_op, id_funct, id_mem_read, id_reg_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  stall, ex_valid, opA, opB, ALUop, ex_rd, ex_reg_write, ex_mem_read,
           ex_store_data, illegal
  );

  modport slave (
    input  flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_alu_op, id_funct, id_mem_read, id_reg_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output stall, ex_valid, opA, opB, ALUop, ex_rd, ex_reg_write, ex_mem_read,
           ex_store_data, illegal
  );

endinterface

// File: rtl/id_ex_operand_stage_alu_control.sv
// ALU control decode: alu_op class plus R-type funct -> 4-bit ALU operation code.
module id_ex_operand_stage_alu_control
  import id_ex_operand_stage_pkg::*;
(
  input  alu_class_e          alu_op,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUOP_W-1:0]  alu_ctl_c,
  output logic                bad_c
);

  always_comb begin
    alu_ctl_c = ALU_ILLEGAL;
    bad_c     = 1'b1;
    case (alu_op)
      ALU_CLS_ADD: begin alu_ctl_c = ALU_ADD; bad_c = 1'b0; end
      ALU_CLS_SUB: begin alu_ctl_c = ALU_SUB; bad_c = 1'b0; end
      ALU_CLS_RTYPE: begin
        bad_c = 1'b0;
        case (funct)
          FN_ADD:  alu_ctl_c = ALU_ADD;
          FN_SUB:  alu_ctl_c = ALU_SUB;
          FN_AND:  alu_ctl_c = ALU_AND;
          FN_OR:   alu_ctl_c = ALU_OR;
          FN_SLT:  alu_ctl_c = ALU_SLT;
          FN_NOR:  alu_ctl_c = ALU_NOR;
          default: begin alu_ctl_c = ALU_ILLEGAL; bad_c = 1'b1; end
        endcase
      end
      default: begin alu_ctl_c = ALU_ILLEGAL; bad_c = 1'b1; end
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding, load-use
// stall detection and ALU control generation.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
)(
  input  logic                  clk,
  input  logic                  reset,
  id_ex_operand_stage_if.slave  bus
);

  typedef struct packed {
    logic               valid;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic [DATA_W-1:0]  rs_data;
    logic [DATA_W-1:0]  rt_data;
    logic [DATA_W-1:0]  imm;
    logic               alu_src;
    alu_class_e         alu_op;
    logic [FUNCT_W-1:0] funct;
    logic               mem_read;
    logic               reg_write;
  } ex_reg_t;

  ex_reg_t            ex_q;
  ex_reg_t            id_c;
  logic               stall_c;
  logic [DATA_W-1:0]  fwd_rs_c;
  logic [DATA_W-1:0]  fwd_rt_c;
  logic [ALUOP_W-1:0] alu_ctl_c;
  logic               alu_bad_c;

  // Younger producer (EX/MEM) wins over MEM/WB; r0 is never forwarded.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [DATA_W-1:0] rf_data,
    input logic              exmem_we,
    input logic [REG_AW-1:0] exmem_rd,
    input logic [DATA_W-1:0] exmem_res,
    input logic              memwb_we,
    input logic [REG_AW-1:0] memwb_rd,
    input logic [DATA_W-1:0] memwb_res
  );
    if (src != '0 && exmem_we && exmem_rd == src)      return exmem_res;
    else if (src != '0 && memwb_we && memwb_rd == src) return memwb_res;
    else                                               return rf_data;
  endfunction

  always_comb begin
    id_c           = '0;
    id_c.valid     = bus.id_valid;
    id_c.rs        = bus.id_rs;
    id_c.rt        = bus.id_rt;
    id_c.rd        = bus.id_rd;
    id_c.rs_data   = bus.id_rs_data;
    id_c.rt_data   = bus.id_rt_data;
    id_c.imm       = bus.id_imm;
    id_c.alu_src   = bus.id_alu_src;
    id_c.alu_op    = bus.id_alu_op;
    id_c.funct     = bus.id_funct;
    id_c.mem_read  = bus.id_mem_read;
    id_c.reg_write = bus.id_reg_write;
  end

  assign stall_c = !bus.flush && bus.id_valid && ex_q.valid && ex_q.mem_read &&
                   (ex_q.rd != '0) && (ex_q.rd == bus.id_rs || ex_q.rd == bus.id_rt);

  // A bubble is an all-zero entry, which also keeps don't-care fields deterministic.
  always_ff @(posedge clk) begin
    if (reset)                        ex_q <= '0;
    else if (bus.flush || stall_c)    ex_q <= '0;
    else                              ex_q <= id_c;
  end

  always_comb begin
    fwd_rs_c = fwd_sel(ex_q.rs, ex_q.rs_data, bus.exmem_reg_write, bus.exmem_rd,
                       bus.exmem_result, bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
    fwd_rt_c = fwd_sel(ex_q.rt, ex_q.rt_data, bus.exmem_reg_write, bus.exmem_rd,
                       bus.exmem_result, bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
  end

  id_ex_operand_stage_alu_control u_alu_control (
    .alu_op    (ex_q.alu_op),
    .funct     (ex_q.funct),
    .alu_ctl_c (alu_ctl_c),
    .bad_c     (alu_bad_c)
  );

  assign bus.stall         = stall_c;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.opA           = fwd_rs_c;
  assign bus.opB           = ex_q.alu_src ? ex_q.imm : fwd_rt_c;
  assign bus.ALUop         = alu_ctl_c;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.valid & ex_q.mem_read;
  assign bus.ex_store_data = fwd_rt_c;
  assign bus.illegal       = ex_q.valid & alu_bad_c;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: stimulus pushes hand-computed expectations
// tagged with the cycle they apply to; a negedge monitor pops and compares them.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {F_STALL, F_VALID, F_OPA, F_OPB, F_ALUOP, F_ILL, F_RW, F_MR, F_RD, F_SD} field_e;

  typedef struct {
    string       name;
    int          cyc;
    field_e      fld;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] sample(field_e f);
    case (f)
      F_STALL: return 32'(bus.stall);
      F_VALID: return 32'(bus.ex_valid);
      F_OPA:   return bus.opA;
      F_OPB:   return bus.opB;
      F_ALUOP: return 32'(bus.ALUop);
      F_ILL:   return 32'(bus.illegal);
      F_RW:    return 32'(bus.ex_reg_write);
      F_MR:    return 32'(bus.ex_mem_read);
      F_RD:    return 32'(bus.ex_rd);
      default: return 32'(bus.ex_store_data);
    endcase
  endfunction

  // Monitor: compare every expectation due at or before the current cycle.
  initial forever begin
    exp_t        e;
    logic [31:0] act;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = sample(e.fld);
      n_checks++;
      if (e.cyc != cyc)
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      else if (act !== e.exp)
        $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", e.name, cyc, act, e.exp);
      else
        n_pass++;
    end
  end

  task automatic chk(input string nm, input field_e f, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.cyc = cyc; e.fld = f; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic src, input alu_class_e aop,
                          input logic [5:0] fn, input logic mr, input logic rw);
    bus.id_valid     = v;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_rs_data   = rsd;
    bus.id_rt_data   = rtd;
    bus.id_imm       = imm;
    bus.id_alu_src   = src;
    bus.id_alu_op    = aop;
    bus.id_funct     = fn;
    bus.id_mem_read  = mr;
    bus.id_reg_write = rw;
  endtask

  task automatic fwd_set(input logic exw, input logic [4:0] exrd, input logic [31:0] exres,
                         input logic mww, input logic [4:0] mwrd, input logic [31:0] mwres);
    bus.exmem_reg_write = exw;
    bus.exmem_rd        = exrd;
    bus.exmem_result    = exres;
    bus.memwb_reg_write = mww;
    bus.memwb_rd        = mwrd;
    bus.memwb_result    = mwres;
  endtask

  initial begin
    reset     = 1'b1;
    bus.flush = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, ALU_CLS_ADD, 6'h0, 1'b0, 1'b0);
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    step(); // c1: post power-up reset, issue R-type add
    reset = 1'b0;
    chk("por_valid", F_VALID, 32'h0);
    chk("por_aluop", F_ALUOP, 32'h2);
    drive_id(1'b1, 5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 32'h0, 1'b0, ALU_CLS_RTYPE, FN_ADD, 1'b0, 1'b1);

    step(); // c2: add in EX; assert reset mid-stream with a valid instr in decode
    chk("add_opA", F_OPA, 32'd5);
    chk("add_opB", F_OPB, 32'd7);
    chk("add_aluop", F_ALUOP, 32'h2);
    chk("add_valid", F_VALID, 32'h1);
    chk("add_rd", F_RD, 32'd9);
    chk("add_rw", F_RW, 32'h1);
    chk("add_sd", F_SD, 32'd7);
    chk("add_ill", F_ILL, 32'h0);
    reset = 1'b1;
    drive_id(1'b1, 5'd3, 5'd3, 5'd5, 32'h1, 32'h1, 32'h0, 1'b0, ALU_CLS_ADD, 6'h0, 1'b0, 1'b1);

    step(); // c3: reset values
    reset = 1'b0;
    chk("rst_valid", F_VALID, 32'h0);
    chk("rst_opA", F_OPA, 32'h0);
    chk("rst_opB", F_OPB, 32'h0);
    chk("rst_aluop", F_ALUOP, 32'h2);
    chk("rst_rd", F_RD, 32'h0);
    chk("rst_rw", F_RW, 32'h0);
    chk("rst_mr", F_MR, 32'h0);
    chk("rst_sd", F_SD, 32'h0);
    chk("rst_ill", F_ILL, 32'h0);
    chk("rst_stall", F_STALL, 32'h0);
    drive_id(1'b1, 5'd3, 5'd0, 5'd6, 32'h11, 32'h0, 32'h0, 1'b0, ALU_CLS_ADD, 6'h0, 1'b0, 1'b1);

    step(); // c4: both stages write r3, EX/MEM wins
    fwd_set(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    chk("fwd_exmem", F_OPA, 32'hAA);
    chk("fwd_valid", F_VALID, 32'h1);

    step(); // c5
    fwd_set(1'b1, 5'd0, 32'hAA, 1'b1, 5'd3, 32'hBB);
    chk("fwd_memwb", F_OPA, 32'hBB);

    step(); // c6
    fwd_set(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    chk("fwd_rf", F_OPA, 32'h11);
    drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h100, 32'h0, 32'd8, 1'b1, ALU_CLS_ADD, 6'h0, 1'b1, 1'b1);

    step(); // c7: load r4 in EX, dependent instr in decode
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("ld_mr", F_MR, 32'h1);
    chk("ld_rd", F_RD, 32'd4);
    chk("ld_opA", F_OPA, 32'h100);
    chk("ld_opB", F_OPB, 32'd8);
    drive_id(1'b1, 5'd5, 5'd4, 5'd7, 32'h50, 32'h0, 32'h0, 1'b0, ALU_CLS_RTYPE, FN_ADD, 1'b0, 1'b1);
    chk("lu_stall", F_STALL, 32'h1);

    step(); // c8: bubble
    fwd_set(1'b1, 5'd4, 32'h108, 1'b0, 5'd0, 32'h0);
    chk("bub_valid", F_VALID, 32'h0);
    chk("bub_stall", F_STALL, 32'h0);
    chk("bub_mr", F_MR, 32'h0);
    chk("bub_rw", F_RW, 32'h0);

    step(); // c9: dependent issues with load data from MEM/WB
    fwd_set(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hDEAD);
    chk("dep_valid", F_VALID, 32'h1);
    chk("dep_opA", F_OPA, 32'h50);
    chk("dep_opB", F_OPB, 32'hDEAD);
    chk("dep_sd", F_SD, 32'hDEAD);
    chk("dep_rd", F_RD, 32'd7);
    chk("dep_stall", F_STALL, 32'h0);
    drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h100, 32'h0, 32'd8, 1'b1, ALU_CLS_ADD, 6'h0, 1'b1, 1'b1);

    step(); // c10: load in EX, hazard in decode, but flush
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("fl_mr", F_MR, 32'h1);
    drive_id(1'b1, 5'd5, 5'd4, 5'd7, 32'h50, 32'h0, 32'h0, 1'b0, ALU_CLS_RTYPE, FN_ADD, 1'b0, 1'b1);
    bus.flush = 1'b1;
    chk("fl_stall", F_STALL, 32'h0);

    step(); // c11
    bus.flush = 1'b0;
    chk("fl_valid", F_VALID, 32'h0);
    chk("fl_rw", F_RW, 32'h0);
    chk("fl_mr0", F_MR, 32'h0);
    drive_id(1'b1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 1'b0, ALU_CLS_RTYPE, 6'b000000, 1'b0, 1'b1);

    step(); // c12: bad funct
    chk("badfn_aluop", F_ALUOP, 32'hF);
    chk("badfn_ill", F_ILL, 32'h1);
    drive_id(1'b1, 5'd1, 5'd2, 5'd9, 32'd3, 32'd9, 32'h0, 1'b0, ALU_CLS_RTYPE, FN_SLT, 1'b0, 1'b1);

    step(); // c13: slt
    chk("slt_aluop", F_ALUOP, 32'h7);
    chk("slt_ill", F_ILL, 32'h0);
    chk("slt_opA", F_OPA, 32'd3);
    chk("slt_opB", F_OPB, 32'd9);
    drive_id(1'b1, 5'd1, 5'd2, 5'd9, 32'd10, 32'd0, 32'hFFFF_FFFC, 1'b1, ALU_CLS_SUB, 6'h0, 1'b0, 1'b1);

    step(); // c14: immediate operand
    chk("imm_opB", F_OPB, 32'hFFFF_FFFC);
    chk("imm_aluop", F_ALUOP, 32'h6);
    chk("imm_opA", F_OPA, 32'd10);
    drive_id(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, ALU_CLS_BAD, 6'h0, 1'b0, 1'b1);

    step(); // c15: alu_op 11
    chk("op11_aluop", F_ALUOP, 32'hF);
    chk("op11_ill", F_ILL, 32'h1);
    drive_id(1'b0, 5'd4, 5'd4, 5'd4, 32'h0, 32'h0, 32'h0, 1'b0, ALU_CLS_BAD, 6'h0, 1'b1, 1'b1);

    step(); // c16: invalid entry with stale control bits
    chk("inv_aluop", F_ALUOP, 32'hF);
    chk("inv_ill", F_ILL, 32'h0);
    chk("inv_rw", F_RW, 32'h0);
    chk("inv_mr", F_MR, 32'h0);
    chk("inv_valid", F_VALID, 32'h0);
    drive_id(1'b1, 5'd4, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0, ALU_CLS_RTYPE, FN_AND, 1'b0, 1'b1);
    chk("inv_stall", F_STALL, 32'h0);

    step(); // c17: and
    chk("and_aluop", F_ALUOP, 32'h0);
    chk("and_valid", F_VALID, 32'h1);
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, ALU_CLS_ADD, 6'h0, 1'b0, 1'b0);

    step();
    step();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      $display("FAIL %s: expectation for cycle %0d never compared", e.name, e.cyc);
    end
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    if (!done) begin
      $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
    end
  end

endmodule
